overlay_bounce_ctrl: RTL and testbench



---
 rtl/overlay_bounce_ctrl_pkg.sv | 16 +
 rtl/overlay_bounce_ctrl_if.sv | 12 +
 rtl/overlay_bounce_ctrl_axis_step.sv | 41 ++++
 rtl/overlay_bounce_ctrl.sv | 125 ++++++++++++
 tb/tb_overlay_bounce_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/overlay_bounce_ctrl_pkg.sv
// rtl/overlay_bounce_ctrl_pkg.sv - shared cell geometry and sequencer state encoding
package overlay_pkg;

  localparam int CELL_SHIFT   = 3;
  localparam int SCR_W_CELLS  = 80;
  localparam int SCR_H_CELLS  = 60;
  localparam int TEXT_W_CELLS = 47;
  localparam int TEXT_H_CELLS = 9;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    MOVE   = 2'd1,
    PAUSED = 2'd2
  } ovl_state_e;

endpackage

// File: rtl/overlay_bounce_ctrl_if.sv
// rtl/overlay_bounce_ctrl_if.sv - pixel-side link between the renderer and the bounce sequencer
interface overlay_bounce_ctrl_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       glyph_on;
  logic [6:0] local_x;
  logic [5:0] local_y;
  logic       overlay_active;

  modport master (output x, y, glyph_on, input local_x, local_y, overlay_active);
  modport slave  (input x, y, glyph_on, output local_x, local_y, overlay_active);
endinterface

// File: rtl/overlay_bounce_ctrl_axis_step.sv
// rtl/overlay_bounce_ctrl_axis_step.sv - one axis of the banner origin with edge reflection
module overlay_axis_step #(
  parameter int W    = 7,
  parameter int MAX  = 33,
  parameter int INIT = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] org,
  output logic         dir
);

  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] INIT_V = W'(INIT);

  // A wall hit turns around inside the same step, so the banner never dwells on the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      org <= INIT_V;
      dir <= 1'b0;
    end else if (step) begin
      if (!dir) begin
        if (org == MAX_V) begin
          dir <= 1'b1;
          org <= MAX_V - 1'b1;
        end else begin
          org <= org + 1'b1;
        end
      end else begin
        if (org == '0) begin
          dir <= 1'b0;
          org <= W'(1);
        end else begin
          org <= org - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/overlay_bounce_ctrl.sv
// rtl/overlay_bounce_ctrl.sv - per-frame bouncing banner sequencer; OVERLAY_BOUNCE_BLINK_EN adds a post-bounce blink
module overlay_bounce_ctrl #(
  parameter int TEXT_W_CELLS    = overlay_pkg::TEXT_W_CELLS,
  parameter int TEXT_H_CELLS    = overlay_pkg::TEXT_H_CELLS,
  parameter int SCR_W_CELLS     = overlay_pkg::SCR_W_CELLS,
  parameter int SCR_H_CELLS     = overlay_pkg::SCR_H_CELLS,
  parameter int INIT_X          = 18,
  parameter int INIT_Y          = 12,
  parameter int FRAMES_PER_STEP = 2,
  parameter int HOLD_FRAMES     = 60
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    frame_tick,
  input  logic                    pause,
  overlay_bounce_ctrl_if.slave    pix,
  output logic [6:0]              org_x,
  output logic [5:0]              org_y,
  output logic                    dir_x,
  output logic                    dir_y,
  output logic [1:0]              state
);
  import overlay_pkg::*;

  localparam int MAX_X = SCR_W_CELLS - TEXT_W_CELLS;
  localparam int MAX_Y = SCR_H_CELLS - TEXT_H_CELLS;
  localparam int HW    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int DW    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(FRAMES_PER_STEP - 1);

  ovl_state_e     state_q;
  logic [HW-1:0]  hold_q;
  logic [DW-1:0]  div_q;
  logic           tick_en;
  logic           step;
  logic           in_box;
  logic           blink_gate;
  logic           unused_y;

  assign tick_en = ena && frame_tick;
  assign step    = tick_en && (state_q == MOVE) && !pause && (div_q == DIV_LAST);
  assign state   = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HOLD;
      hold_q  <= '0;
      div_q   <= '0;
    end else if (!(state_q inside {HOLD, MOVE, PAUSED})) begin
      state_q <= HOLD;
      hold_q  <= '0;
      div_q   <= '0;
    end else if (tick_en) begin
      case (state_q)
        HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= pause ? PAUSED : MOVE;
            div_q   <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        MOVE: begin
          if (pause)                  state_q <= PAUSED;
          else if (div_q == DIV_LAST) div_q   <= '0;
          else                        div_q   <= div_q + 1'b1;
        end
        PAUSED: begin
          if (!pause) begin
            state_q <= MOVE;
            div_q   <= '0;
          end
        end
        default: state_q <= HOLD;
      endcase
    end
  end

  overlay_axis_step #(.W(7), .MAX(MAX_X), .INIT(INIT_X)) u_axis_x (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step),
    .org   (org_x),
    .dir   (dir_x)
  );

  overlay_axis_step #(.W(6), .MAX(MAX_Y), .INIT(INIT_Y)) u_axis_y (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step),
    .org   (org_y),
    .dir   (dir_y)
  );

`ifdef OVERLAY_BOUNCE_BLINK_EN
  logic [4:0] blink_q;
  logic       reflect;

  assign reflect = step && ((!dir_x && org_x == 7'(MAX_X)) || (dir_x && org_x == 7'd0) ||
                            (!dir_y && org_y == 6'(MAX_Y)) || (dir_y && org_y == 6'd0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_q <= '0;
    end else if (tick_en && state_q != PAUSED) begin
      if (reflect)             blink_q <= 5'd16;
      else if (blink_q != '0)  blink_q <= blink_q - 5'd1;
    end
  end

  assign blink_gate = (blink_q == '0) || !blink_q[2];
`else
  assign blink_gate = 1'b1;
`endif

  // Offsets left of / above the origin wrap to large values and fall outside the box.
  assign pix.local_x = pix.x[CELL_SHIFT +: 7] - org_x;
  assign pix.local_y = pix.y[CELL_SHIFT +: 6] - org_y;
  assign in_box      = (pix.local_x < 7'(TEXT_W_CELLS)) && (pix.local_y < 6'(TEXT_H_CELLS));
  assign pix.overlay_active = ena && rst_n && in_box && pix.glyph_on && blink_gate;
  assign unused_y    = pix.y[9];

endmodule

// File: tb/tb_overlay_bounce_ctrl.sv
// tb/tb_overlay_bounce_ctrl.sv - model-based bench for overlay_bounce_ctrl (two parameter sets)
module tb_overlay_bounce_ctrl;

  logic clk = 1'b0;
  logic rst_n, ena, frame_tick, pause;
  logic [9:0] x_drv, y_drv;
  logic glyph_drv;
  int n_checks = 0;
  int n_err = 0;
  bit model_valid = 0;

  logic [6:0] orgx[2];
  logic [5:0] orgy[2];
  logic       dx[2], dy[2];
  logic [1:0] st[2];
  logic [6:0] lx[2];
  logic [5:0] ly[2];
  logic       act[2];

  int m_st[2], m_hc[2], m_div[2], m_n[2], m_blink[2];

  always #5 clk = ~clk;

  overlay_bounce_ctrl_if ifc0 ();
  overlay_bounce_ctrl_if ifc1 ();
  assign ifc0.x = x_drv;  assign ifc0.y = y_drv;  assign ifc0.glyph_on = glyph_drv;
  assign ifc1.x = x_drv;  assign ifc1.y = y_drv;  assign ifc1.glyph_on = glyph_drv;
  assign lx[0] = ifc0.local_x;  assign ly[0] = ifc0.local_y;  assign act[0] = ifc0.overlay_active;
  assign lx[1] = ifc1.local_x;  assign ly[1] = ifc1.local_y;  assign act[1] = ifc1.overlay_active;

  overlay_bounce_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .frame_tick(frame_tick), .pause(pause), .pix(ifc0),
    .org_x(orgx[0]), .org_y(orgy[0]), .dir_x(dx[0]), .dir_y(dy[0]), .state(st[0])
  );

  overlay_bounce_ctrl #(.INIT_X(32), .INIT_Y(50), .FRAMES_PER_STEP(1), .HOLD_FRAMES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .frame_tick(frame_tick), .pause(pause), .pix(ifc1),
    .org_x(orgx[1]), .org_y(orgy[1]), .dir_x(dx[1]), .dir_y(dy[1]), .state(st[1])
  );

  function automatic int hold_p(int i);  return (i == 0) ? 60 : 1;  endfunction
  function automatic int fps_p(int i);   return (i == 0) ? 2 : 1;   endfunction
  function automatic int initx_p(int i); return (i == 0) ? 18 : 32; endfunction
  function automatic int inity_p(int i); return (i == 0) ? 12 : 50; endfunction

  // Position after n steps is a triangle wave of period 2*MAX through the start point.
  function automatic int tri_org(int init, int n, int mx);
    int p;
    p = (init + n) % (2 * mx);
    return (p <= mx) ? p : 2 * mx - p;
  endfunction

  function automatic int tri_dir(int init, int n, int mx);
    int p;
    p = (init + n) % (2 * mx);
    if (p == 0) return (n == 0 && init == 0) ? 0 : 1;
    return (p > mx) ? 1 : 0;
  endfunction

  function automatic int exp_x(int i); return tri_org(initx_p(i), m_n[i], 33); endfunction
  function automatic int exp_y(int i); return tri_org(inity_p(i), m_n[i], 51); endfunction

  task automatic check(input string nm, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, actual, required, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_valid = 1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_st[i] = 0; m_hc[i] = 0; m_div[i] = 0; m_n[i] = 0; m_blink[i] = 0;
      end else if (ena && frame_tick) begin
        automatic int st0 = m_st[i];
        automatic bit stp = 0;
        automatic bit refl;
        case (st0)
          0: begin
            m_hc[i]++;
            if (m_hc[i] == hold_p(i)) begin m_st[i] = pause ? 2 : 1; m_div[i] = 0; end
          end
          1: begin
            if (pause) m_st[i] = 2;
            else begin
              m_div[i]++;
              if (m_div[i] == fps_p(i)) begin m_div[i] = 0; stp = 1; end
            end
          end
          default: if (!pause) begin m_st[i] = 1; m_div[i] = 0; end
        endcase
        refl = (exp_x(i) == 33 && tri_dir(initx_p(i), m_n[i], 33) == 0) ||
               (exp_x(i) == 0  && tri_dir(initx_p(i), m_n[i], 33) == 1) ||
               (exp_y(i) == 51 && tri_dir(inity_p(i), m_n[i], 51) == 0) ||
               (exp_y(i) == 0  && tri_dir(inity_p(i), m_n[i], 51) == 1);
        if (stp && refl) m_blink[i] = 16;
        else if (st0 != 2 && m_blink[i] > 0) m_blink[i]--;
        if (stp) m_n[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 2; i++) begin
        automatic int ex = exp_x(i);
        automatic int ey = exp_y(i);
        automatic int elx = ((x_drv / 8) - ex) & 127;
        automatic int ely = (((y_drv / 8) % 64) - ey) & 63;
        automatic bit gate = 1;
        automatic bit eact;
`ifdef OVERLAY_BOUNCE_BLINK_EN
        gate = !(m_blink[i] > 0 && (m_blink[i] / 4) % 2 == 1);
`endif
        eact = ena && rst_n && (elx < 47) && (ely < 9) && glyph_drv && gate;
        check($sformatf("org_x[%0d]", i), int'(orgx[i]), ex);
        check($sformatf("org_y[%0d]", i), int'(orgy[i]), ey);
        check($sformatf("dir_x[%0d]", i), int'(dx[i]), tri_dir(initx_p(i), m_n[i], 33));
        check($sformatf("dir_y[%0d]", i), int'(dy[i]), tri_dir(inity_p(i), m_n[i], 51));
        check($sformatf("state[%0d]", i), int'(st[i]), m_st[i]);
        check($sformatf("local_x[%0d]", i), int'(lx[i]), elx);
        check($sformatf("local_y[%0d]", i), int'(ly[i]), ely);
        check($sformatf("overlay_active[%0d]", i), int'(act[i]), int'(eact));
        check($sformatf("bound_x[%0d]", i), int'(orgx[i] <= 7'd33), 1);
        check($sformatf("bound_y[%0d]", i), int'(orgy[i] <= 6'd51), 1);
      end
    end
  end

  task automatic cyc(input logic tk);
    frame_tick = tk;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; pause = 1'b0; frame_tick = 1'b0;
    x_drv = 10'd144; y_drv = 10'd96; glyph_drv = 1'b1;
    cyc(0); cyc(0);
    check("active_in_reset", int'(act[0]), 0);
    check("reset_org_x", int'(orgx[0]), 18);
    check("reset_org_y", int'(orgy[0]), 12);
    check("reset_state", int'(st[0]), 0);
    rst_n = 1'b1; #1;
    check("origin_px_active", int'(act[0]), 1);
    check("origin_px_lx", int'(lx[0]), 0);
    check("origin_px_ly", int'(ly[0]), 0);
    x_drv = 10'd136; #1;
    check("left_px_lx", int'(lx[0]), 127);
    check("left_px_active", int'(act[0]), 0);
    x_drv = 10'd144;

    cyc(1);
    check("b_tick1_state", int'(st[1]), 1);
    check("b_tick1_org_x", int'(orgx[1]), 32);
    cyc(1);
    check("b_tick2_org_x", int'(orgx[1]), 33);
    check("b_tick2_org_y", int'(orgy[1]), 51);
    check("b_tick2_dir_x", int'(dx[1]), 0);
    cyc(1);
    check("b_corner_org_x", int'(orgx[1]), 32);
    check("b_corner_org_y", int'(orgy[1]), 50);
    check("b_corner_dir_x", int'(dx[1]), 1);
    check("b_corner_dir_y", int'(dy[1]), 1);
    repeat (56) begin cyc(1); cyc(0); end
    check("a_tick59_state", int'(st[0]), 0);
    check("a_tick59_org_x", int'(orgx[0]), 18);
    check("a_tick59_org_y", int'(orgy[0]), 12);
    cyc(1);
    check("a_tick60_state", int'(st[0]), 1);
    cyc(1);
    check("a_tick61_org_x", int'(orgx[0]), 18);
    cyc(1);
    check("a_first_step_x", int'(orgx[0]), 19);
    check("a_first_step_y", int'(orgy[0]), 13);

    ena = 1'b0; x_drv = 10'd152; y_drv = 10'd104;
    repeat (4) cyc(1);
    check("ena0_active", int'(act[0]), 0);
    check("ena0_hold_x", int'(orgx[0]), 19);
    check("ena0_hold_y", int'(orgy[0]), 13);
    ena = 1'b1; cyc(0);

    pause = 1'b1; cyc(1);
    check("pause_state", int'(st[0]), 2);
    repeat (5) cyc(1);
    check("paused_org_x", int'(orgx[0]), 19);
    check("paused_org_y", int'(orgy[0]), 13);
    pause = 1'b0; cyc(1);
    check("resume_state", int'(st[0]), 1);
    cyc(1);
    check("resume_div_org_x", int'(orgx[0]), 19);
    cyc(1);
    check("resume_step_x", int'(orgx[0]), 20);
    check("resume_step_y", int'(orgy[0]), 14);

    for (int k = 0; k < 10000; k++) begin
      x_drv = 10'($urandom_range(0, 1023));
      y_drv = 10'($urandom_range(0, 1023));
      glyph_drv = 1'($urandom_range(0, 1));
      ena = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      rst_n = (k != 5000);
      cyc(1'($urandom_range(0, 1)));
    end

    rst_n = 1'b0; cyc(0); rst_n = 1'b1;
    check("final_reset_org_x", int'(orgx[0]), 18);
    check("final_reset_org_y", int'(orgy[0]), 12);
    check("final_reset_state", int'(st[0]), 0);
    cyc(0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
